// File: rtl/mic_fifo_wr_arbiter.sv
// Multi-channel mic sample arbiter: captures per-channel samples, writes them round-robin into a shared FIFO, flushes it when full.
// Optional overrun counter built only when MIC_FIFO_OVERRUN_CNT_EN is defined.
module mic_fifo_wr_arbiter #(
  parameter  int CHANNELS     = 2,
  parameter  int SAMPLE_W     = 16,
  parameter  int CLEAR_CYCLES = 4,
  localparam int CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          spd_rdy,
  input  logic [CHANNELS*SAMPLE_W-1:0] spd_data,
  input  logic                         fifo_full,
  input  logic                         overrun_clr,
  output logic [CHANNELS-1:0]          spd_ack,
  output logic                         wrenable,
  output logic [SAMPLE_W+CH_W-1:0]     fifo_data,
  output logic                         fifo_clear,
  output logic [15:0]                  overrun_count
);

  localparam int CNT_W = $clog2(CLEAR_CYCLES + 1);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]               r_state;
  logic [CNT_W-1:0]         r_clr_cnt;
  logic [CHANNELS-1:0]      r_rdy_d;
  logic [CHANNELS-1:0]      r_pending;
  logic [CH_W-1:0]          r_rr_ptr;
  logic [SAMPLE_W-1:0]      r_hold [CHANNELS];
  logic [CHANNELS-1:0]      r_spd_ack;
  logic                     r_wrenable;
  logic [SAMPLE_W+CH_W-1:0] r_fifo_data;
  logic                     r_fifo_clear;

  logic [CHANNELS-1:0]      w_rise;
  logic [CHANNELS-1:0]      w_pend_hi;
  logic [CHANNELS-1:0]      w_cand;
  logic                     w_flush;
  logic                     w_wr_valid;
  logic [CH_W-1:0]          w_wr_ch;
  logic [CHANNELS-1:0]      w_wr_onehot;
  logic [CHANNELS-1:0]      w_overrun;
  logic [CHANNELS-1:0]      w_pending_next;
  logic [CH_W-1:0]          w_rr_next;

  // w_pend_hi keeps only requests at or above the round-robin pointer; searching it
  // first and falling back to the full vector gives the wrap-around search order.
  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      assign w_rise[gi]    = spd_rdy[gi] & ~r_rdy_d[gi];
      assign w_pend_hi[gi] = r_pending[gi] & (CH_W'(gi) >= r_rr_ptr);
    end
  endgenerate

  assign w_cand  = (|w_pend_hi) ? w_pend_hi : r_pending;
  assign w_flush = (r_state == S_RUN) & fifo_full;

  always_comb begin
    w_wr_valid = 1'b0;
    w_wr_ch    = '0;
    if ((r_state == S_RUN) && !fifo_full && (|r_pending)) begin
      w_wr_valid = 1'b1;
      for (int c = CHANNELS - 1; c >= 0; c--) begin
        if (w_cand[c]) begin
          w_wr_ch = CH_W'(c);
        end
      end
    end
  end

  assign w_wr_onehot = w_wr_valid ? (CHANNELS'(1) << w_wr_ch) : '0;
  assign w_rr_next   = (w_wr_ch == CH_W'(CHANNELS - 1)) ? '0 : (w_wr_ch + CH_W'(1));

  // A sample dropped by the flush is not an overrun; a same-cycle write of c frees the slot.
  assign w_overrun      = w_rise & r_pending & ~w_wr_onehot & {CHANNELS{~w_flush}};
  assign w_pending_next = w_flush ? w_rise : ((r_pending & ~w_wr_onehot) | w_rise);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rdy_d     <= '1;
      r_pending   <= '0;
      r_rr_ptr    <= '0;
      r_spd_ack   <= '0;
      r_wrenable  <= 1'b0;
      r_fifo_data <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        r_hold[c] <= '0;
      end
    end else begin
      r_rdy_d    <= spd_rdy;
      r_pending  <= w_pending_next;
      r_spd_ack  <= spd_rdy;
      r_wrenable <= w_wr_valid;
      if (w_wr_valid) begin
        r_fifo_data <= {w_wr_ch, r_hold[w_wr_ch]};
        r_rr_ptr    <= w_rr_next;
      end
      for (int c = 0; c < CHANNELS; c++) begin
        if (w_rise[c]) begin
          r_hold[c] <= spd_data[c*SAMPLE_W +: SAMPLE_W];
        end
      end
    end
  end

  // Clear counter is loaded on entry; the last clear cycle is when it reads 1.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_RUN;
      r_clr_cnt    <= '0;
      r_fifo_clear <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          if (fifo_full) begin
            r_state      <= S_CLEAR;
            r_clr_cnt    <= CNT_W'(CLEAR_CYCLES);
            r_fifo_clear <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_clr_cnt <= r_clr_cnt - CNT_W'(1);
          if (r_clr_cnt <= CNT_W'(1)) begin
            r_state      <= S_RUN;
            r_fifo_clear <= 1'b0;
          end
        end
        default: begin
          r_state      <= S_RUN;
          r_fifo_clear <= 1'b0;
        end
      endcase
    end
  end

`ifdef MIC_FIFO_OVERRUN_CNT_EN
  logic [15:0] r_overrun_count;
  logic [3:0]  w_ovr_num;
  logic [16:0] w_ovr_sum;

  always_comb begin
    w_ovr_num = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      w_ovr_num = w_ovr_num + 4'(w_overrun[c]);
    end
  end

  assign w_ovr_sum = {1'b0, r_overrun_count} + 17'(w_ovr_num);

  always_ff @(posedge clock) begin
    if (reset || overrun_clr) begin
      r_overrun_count <= '0;
    end else if (w_ovr_sum[16]) begin
      r_overrun_count <= 16'hFFFF;
    end else begin
      r_overrun_count <= w_ovr_sum[15:0];
    end
  end

  assign overrun_count = r_overrun_count;
`else
  logic w_unused;
  assign w_unused      = overrun_clr ^ (|w_overrun);
  assign overrun_count = '0;
`endif

  assign spd_ack    = r_spd_ack;
  assign wrenable   = r_wrenable;
  assign fifo_data  = r_fifo_data;
  assign fifo_clear = r_fifo_clear;

endmodule

// File: tb/tb_mic_fifo_wr_arbiter.sv
// Directed testbench for mic_fifo_wr_arbiter: a 2-channel and a 4-channel instance on one clock.
// Overrun-count expectations follow MIC_FIFO_OVERRUN_CNT_EN (zero when the counter is not built).
module tb_mic_fifo_wr_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;

  logic [1:0]  rdy2;
  logic [31:0] data2;
  logic        full2;
  logic        oclr2;
  logic [1:0]  ack2;
  logic        wr2;
  logic [16:0] fd2;
  logic        clr2;
  logic [15:0] oc2;

  logic [3:0]  rdy4;
  logic [63:0] data4;
  logic        full4;
  logic        oclr4;
  logic [3:0]  ack4;
  logic        wr4;
  logic [17:0] fd4;
  logic        clr4;
  logic [15:0] oc4;

`ifdef MIC_FIFO_OVERRUN_CNT_EN
  localparam logic [15:0] EXP_OVR1 = 16'd1;
  localparam logic [15:0] EXP_OVR2 = 16'd2;
`else
  localparam logic [15:0] EXP_OVR1 = 16'd0;
  localparam logic [15:0] EXP_OVR2 = 16'd0;
`endif

  int checks = 0;
  int errors = 0;

  mic_fifo_wr_arbiter #(.CHANNELS(2), .SAMPLE_W(16), .CLEAR_CYCLES(4)) u_dut2 (
    .clock(clk), .reset(srst), .spd_rdy(rdy2), .spd_data(data2), .fifo_full(full2),
    .overrun_clr(oclr2), .spd_ack(ack2), .wrenable(wr2), .fifo_data(fd2),
    .fifo_clear(clr2), .overrun_count(oc2)
  );

  mic_fifo_wr_arbiter #(.CHANNELS(4), .SAMPLE_W(16), .CLEAR_CYCLES(4)) u_dut4 (
    .clock(clk), .reset(srst), .spd_rdy(rdy4), .spd_data(data4), .fifo_full(full4),
    .overrun_clr(oclr4), .spd_ack(ack4), .wrenable(wr4), .fifo_data(fd4),
    .fifo_clear(clr4), .overrun_count(oc4)
  );

  always @(negedge clk) begin
    if (wr2) $display("dut2 write ch=%0d data=%h", fd2[16], fd2[15:0]);
    if (wr4) $display("dut4 write ch=%0d data=%h", fd4[17:16], fd4[15:0]);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    srst = 1'b1;
    step();
    step();
    checks++; if (wr4 !== 1'b0 || wr2 !== 1'b0) begin errors++; $display("FAIL reset_wr: wr4=%b wr2=%b expected 0", wr4, wr2); end
    checks++; if (fd4 !== 18'h0 || fd2 !== 17'h0) begin errors++; $display("FAIL reset_data: fd4=%h fd2=%h expected 0", fd4, fd2); end
    checks++; if (clr4 !== 1'b0 || clr2 !== 1'b0) begin errors++; $display("FAIL reset_clear: clr4=%b clr2=%b expected 0", clr4, clr2); end
    checks++; if (oc4 !== 16'h0 || oc2 !== 16'h0) begin errors++; $display("FAIL reset_ovr: oc4=%h oc2=%h expected 0", oc4, oc2); end
    checks++; if (ack4 !== 4'h0 || ack2 !== 2'h0) begin errors++; $display("FAIL reset_ack: ack4=%b ack2=%b expected 0", ack4, ack2); end
    srst = 1'b0;
    step();
  endtask

  task automatic test_single_ch2();
    data2 = {16'h0000, 16'h1234};
    rdy2  = 2'b01;
    step();
    checks++; if (ack2 !== 2'b01) begin errors++; $display("FAIL single_ack: ack=%b expected 01", ack2); end
    checks++; if (wr2 !== 1'b0) begin errors++; $display("FAIL single_early: wr=%b expected 0", wr2); end
    step();
    checks++; if (wr2 !== 1'b1 || fd2 !== 17'h0_1234) begin errors++; $display("FAIL single_write: wr=%b data=%h expected wr=1 data=01234", wr2, fd2); end
    step();
    checks++; if (wr2 !== 1'b0) begin errors++; $display("FAIL single_once: wr=%b expected 0", wr2); end
    rdy2 = 2'b00;
    step();
    checks++; if (ack2 !== 2'b00) begin errors++; $display("FAIL single_ack_low: ack=%b expected 00", ack2); end
  endtask

  task automatic test_round_robin();
    logic [15:0] samp [4];
    logic [17:0] exp_fd;
    for (int b = 0; b < 2; b++) begin
      for (int c = 0; c < 4; c++) begin
        samp[c] = 16'(32'hA000 + b * 32'h0100 + c * 32'h1111);
        data4[c*16 +: 16] = samp[c];
      end
      rdy4 = 4'hF;
      step();
      rdy4 = 4'h0;
      checks++; if (wr4 !== 1'b0) begin errors++; $display("FAIL rr_burst%0d_capture: wr=%b expected 0", b, wr4); end
      for (int c = 0; c < 4; c++) begin
        step();
        exp_fd = {c[1:0], samp[c]};
        checks++; if (wr4 !== 1'b1 || fd4 !== exp_fd) begin errors++; $display("FAIL rr_burst%0d_w%0d: wr=%b data=%h expected wr=1 data=%h", b, c, wr4, fd4, exp_fd); end
      end
      step();
      checks++; if (wr4 !== 1'b0) begin errors++; $display("FAIL rr_burst%0d_idle: wr=%b expected 0", b, wr4); end
    end
  endtask

  task automatic test_full_clear();
    data4[31:16] = 16'h5555;
    rdy4 = 4'b0010;
    step();
    full4 = 1'b1;
    rdy4  = 4'b0000;
    step();
    full4 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (clr4 !== 1'b1 || wr4 !== 1'b0) begin errors++; $display("FAIL clear_cycle%0d: clr=%b wr=%b expected clr=1 wr=0", i, clr4, wr4); end
      if (i == 1) begin data4[15:0] = 16'h7777; rdy4 = 4'b0001; end
      if (i == 2) rdy4 = 4'b0000;
      step();
    end
    checks++; if (clr4 !== 1'b0 || wr4 !== 1'b0) begin errors++; $display("FAIL clear_end: clr=%b wr=%b expected clr=0 wr=0", clr4, wr4); end
    step();
    checks++; if (wr4 !== 1'b1 || fd4 !== {2'd0, 16'h7777}) begin errors++; $display("FAIL clear_resume: wr=%b data=%h expected wr=1 data=07777", wr4, fd4); end
    step();
    checks++; if (wr4 !== 1'b0) begin errors++; $display("FAIL clear_discard: wr=%b data=%h expected wr=0", wr4, fd4); end
  endtask

  task automatic test_full_edges();
    data4[15:0] = 16'h0C01;
    rdy4 = 4'b0001;
    step();
    full4 = 1'b1;
    rdy4  = 4'b0000;
    step();
    full4 = 1'b0;
    data4[15:0] = 16'h0C02;
    rdy4 = 4'b0001;
    step();
    rdy4 = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (wr4 !== 1'b0) begin errors++; $display("FAIL edges_blocked%0d: wr=%b expected 0", i, wr4); end
    end
    checks++; if (clr4 !== 1'b0) begin errors++; $display("FAIL edges_clear_end: clr=%b expected 0", clr4); end
    step();
    checks++; if (wr4 !== 1'b1 || fd4 !== {2'd0, 16'h0C02}) begin errors++; $display("FAIL edges_write: wr=%b data=%h expected wr=1 data=00c02", wr4, fd4); end
    checks++; if (oc4 !== 16'h0) begin errors++; $display("FAIL edges_no_overrun: count=%0d expected 0", oc4); end
    step();
    checks++; if (wr4 !== 1'b0) begin errors++; $display("FAIL edges_single: wr=%b expected 0", wr4); end
  endtask

  task automatic test_overrun();
    full4 = 1'b1;
    step();
    full4 = 1'b0;
    data4[47:32] = 16'h2001;
    rdy4 = 4'b0100;
    step();
    rdy4 = 4'b0000;
    step();
    data4[47:32] = 16'h2002;
    rdy4 = 4'b0100;
    step();
    checks++; if (oc4 !== EXP_OVR1) begin errors++; $display("FAIL ovr_first: count=%0d expected %0d", oc4, EXP_OVR1); end
    data4[15:0]  = 16'h0B0B;
    data4[31:16] = 16'h1A1A;
    rdy4 = 4'b0011;
    step();
    checks++; if (clr4 !== 1'b0 || wr4 !== 1'b0) begin errors++; $display("FAIL ovr_clear_end: clr=%b wr=%b expected 0 0", clr4, wr4); end
    data4[47:32] = 16'h2003;
    rdy4 = 4'b0100;
    step();
    checks++; if (wr4 !== 1'b1 || fd4 !== {2'd1, 16'h1A1A}) begin errors++; $display("FAIL ovr_w_ch1: wr=%b data=%h expected wr=1 data=11a1a", wr4, fd4); end
    rdy4 = 4'b0000;
    step();
    checks++; if (wr4 !== 1'b1 || fd4 !== {2'd2, 16'h2003}) begin errors++; $display("FAIL ovr_w_ch2: wr=%b data=%h expected wr=1 data=22003", wr4, fd4); end
    step();
    checks++; if (wr4 !== 1'b1 || fd4 !== {2'd0, 16'h0B0B}) begin errors++; $display("FAIL ovr_w_ch0: wr=%b data=%h expected wr=1 data=00b0b", wr4, fd4); end
    checks++; if (oc4 !== EXP_OVR2) begin errors++; $display("FAIL ovr_count: count=%0d expected %0d", oc4, EXP_OVR2); end
    step();
    checks++; if (wr4 !== 1'b0) begin errors++; $display("FAIL ovr_idle: wr=%b expected 0", wr4); end
    oclr4 = 1'b1;
    step();
    oclr4 = 1'b0;
    checks++; if (oc4 !== 16'h0) begin errors++; $display("FAIL ovr_clr: count=%0d expected 0", oc4); end
  endtask

  task automatic test_reset_level();
    srst = 1'b1;
    data4[15:0]  = 16'hDEAD;
    data4[47:32] = 16'hBEEF;
    rdy4 = 4'b0101;
    step();
    step();
    srst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (wr4 !== 1'b0 || oc4 !== 16'h0) begin errors++; $display("FAIL level_no_write%0d: wr=%b count=%0d expected wr=0 count=0", i, wr4, oc4); end
    end
    checks++; if (ack4 !== 4'b0101) begin errors++; $display("FAIL level_ack: ack=%b expected 0101", ack4); end
    rdy4 = 4'b0000;
    step();
    checks++; if (wr4 !== 1'b0) begin errors++; $display("FAIL level_fall: wr=%b expected 0", wr4); end
  endtask

  task automatic test_reset_mid_clear();
    full4 = 1'b1;
    step();
    full4 = 1'b0;
    checks++; if (clr4 !== 1'b1) begin errors++; $display("FAIL midclr_enter: clr=%b expected 1", clr4); end
    step();
    checks++; if (clr4 !== 1'b1) begin errors++; $display("FAIL midclr_hold: clr=%b expected 1", clr4); end
    srst = 1'b1;
    step();
    checks++; if (clr4 !== 1'b0 || wr4 !== 1'b0) begin errors++; $display("FAIL midclr_reset: clr=%b wr=%b expected 0 0", clr4, wr4); end
    srst = 1'b0;
    step();
    checks++; if (clr4 !== 1'b0) begin errors++; $display("FAIL midclr_after: clr=%b expected 0", clr4); end
    data4[63:48] = 16'h3333;
    rdy4 = 4'b1000;
    step();
    rdy4 = 4'b0000;
    step();
    checks++; if (wr4 !== 1'b1 || fd4 !== {2'd3, 16'h3333}) begin errors++; $display("FAIL midclr_resume: wr=%b data=%h expected wr=1 data=33333", wr4, fd4); end
  endtask

  initial begin
    srst  = 1'b1;
    rdy2  = '0; data2 = '0; full2 = 1'b0; oclr2 = 1'b0;
    rdy4  = '0; data4 = '0; full4 = 1'b0; oclr4 = 1'b0;
    test_reset();
    test_single_ch2();
    test_round_robin();
    test_full_clear();
    test_full_edges();
    test_overrun();
    test_reset_level();
    test_reset_mid_clear();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1, "timeout");
  end

endmodule
